muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the sequential multiply/divide unit.
// Imported by the iteration datapath and the top-level controller.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   typedef enum logic {
      STEP_MUL = 1'b0,
      STEP_DIV = 1'b1
   } step_mode_e;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: radix-2 shift-add multiply step or
// restoring-division step, operating on an accumulator plus a low word.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  step_mode_e       mode,
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] low,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH:0]   acc_next,
   output logic [WIDTH-1:0] low_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic             borrow;

   // Multiply: acc holds the upper product half, low holds the not-yet-consumed
   // multiplier bits; the carry out of the add shifts into the upper half.
   assign sum = acc + (low[0] ? {1'b0, opnd} : '0);

   // Divide: acc is the partial remainder, low shifts dividend bits out of its
   // top and quotient bits into its bottom.
   assign shifted = {acc, low[WIDTH-1]};
   assign diff    = shifted - {2'b00, opnd};
   assign borrow  = diff[WIDTH+1];

   always_comb begin
      acc_next = '0;
      low_next = '0;
      if (mode == STEP_MUL) begin
         acc_next = {1'b0, sum[WIDTH:1]};
         low_next = {sum[0], low[WIDTH-1:1]};
      end else begin
         acc_next = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
         low_next = {low[WIDTH-2:0], ~borrow};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Sequential signed/unsigned multiply/divide unit with HI/LO registers,
// start/done handshake, divide-by-zero flag and direct MTHI/MTLO writes.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state;
   state_e           state_next;
   op_e              op_cur;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] low;
   logic [WIDTH-1:0] opnd;
   logic [CW-1:0]    cnt;

   logic             signed_in;
   logic             div_in;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             dz_hit;
   logic             last_iter;

   logic             is_div;
   logic             neg_res;
   logic [WIDTH:0]   acc_next;
   logic [WIDTH-1:0] low_next;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] hi_res;
   logic [WIDTH-1:0] lo_res;

   // Magnitudes are held unsigned, so the most-negative value maps to 2^(W-1).
   assign signed_in = ~op[0];
   assign div_in    = op[1];
   assign mag_a     = (signed_in && a[WIDTH-1]) ? -a : a;
   assign mag_b     = (signed_in && b[WIDTH-1]) ? -b : b;
   assign dz_hit    = start && div_in && (b == '0);
   assign last_iter = (cnt == CW'(WIDTH - 1));

   assign is_div  = (op_cur == OP_DIV) || (op_cur == OP_DIVU);
   assign neg_res = sign_a ^ sign_b;

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .mode     (is_div ? STEP_DIV : STEP_MUL),
      .acc      (acc),
      .low      (low),
      .opnd     (opnd),
      .acc_next (acc_next),
      .low_next (low_next)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start && !dz_hit) state_next = ST_RUN;
         ST_RUN:  if (last_iter) state_next = ST_FIX;
         ST_FIX:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Sign fix-up: only the signed ops negate; remainder follows the dividend.
   always_comb begin
      prod     = {acc[WIDTH-1:0], low};
      prod_fix = (op_cur == OP_MULT && neg_res) ? -prod : prod;
      quo_fix  = (op_cur == OP_DIV && neg_res) ? -low : low;
      rem_fix  = (op_cur == OP_DIV && sign_a) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      hi_res   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      lo_res   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         op_cur   <= OP_MULT;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         acc      <= '0;
         low      <= '0;
         opnd     <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         state <= state_next;
         done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  op_cur   <= op_e'(op);
                  sign_a   <= signed_in & a[WIDTH-1];
                  sign_b   <= signed_in & b[WIDTH-1];
                  div_zero <= dz_hit;
                  cnt      <= '0;
                  acc      <= '0;
                  low      <= div_in ? mag_a : mag_b;
                  opnd     <= div_in ? mag_b : mag_a;
                  if (dz_hit) done <= 1'b1;
               end
            end
            ST_RUN: begin
               acc <= acc_next;
               low <= low_next;
               cnt <= cnt + CW'(1);
            end
            ST_FIX: begin
               hi   <= hi_res;
               lo   <= lo_res;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8,
// compared against an arithmetic reference model.
module tb_muldiv_unit;

   localparam logic [1:0] MULT  = 2'b00;
   localparam logic [1:0] MULTU = 2'b01;
   localparam logic [1:0] DIV   = 2'b10;
   localparam logic [1:0] DIVU  = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start32, start8;
   logic        hi_we32, lo_we32, hi_we8, lo_we8;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy32, done32, dz32;
   logic [31:0] hi32, lo32;
   logic        busy8, done8, dz8;
   logic [7:0]  hi8, lo8;

   logic        sel8;
   logic        busy_o, done_o, dz_o;
   logic [31:0] hi_o, lo_o;
   logic [31:0] exp_hi [2];
   logic [31:0] exp_lo [2];

   int total = 0;
   int bad   = 0;

   muldiv_unit #(
      .WIDTH (32)
   ) u_dut32 (
      .clk      (clk),
      .reset    (reset),
      .start    (start32),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi_we    (hi_we32),
      .lo_we    (lo_we32),
      .wdata    (wdata),
      .busy     (busy32),
      .done     (done32),
      .div_zero (dz32),
      .hi       (hi32),
      .lo       (lo32)
   );

   muldiv_unit #(
      .WIDTH (8)
   ) u_dut8 (
      .clk      (clk),
      .reset    (reset),
      .start    (start8),
      .op       (op),
      .a        (a[7:0]),
      .b        (b[7:0]),
      .hi_we    (hi_we8),
      .lo_we    (lo_we8),
      .wdata    (wdata[7:0]),
      .busy     (busy8),
      .done     (done8),
      .div_zero (dz8),
      .hi       (hi8),
      .lo       (lo8)
   );

   always_comb begin
      busy_o = sel8 ? busy8 : busy32;
      done_o = sel8 ? done8 : done32;
      dz_o   = sel8 ? dz8 : dz32;
      hi_o   = sel8 ? {24'd0, hi8} : hi32;
      lo_o   = sel8 ? {24'd0, lo8} : lo32;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: sign-extend to 64 bits, use native multiply/divide, split result.
   function automatic void model(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                                 input int w, output logic [63:0] eh, output logic [63:0] el);
      logic [63:0] mask, sbit, p;
      longint ua, ub, sa, sb;
      mask = (64'd1 << w) - 64'd1;
      sbit = 64'd1 << (w - 1);
      ua   = longint'({32'd0, aa} & mask);
      ub   = longint'({32'd0, bb} & mask);
      sa   = longint'((64'(ua) ^ sbit) - sbit);
      sb   = longint'((64'(ub) ^ sbit) - sbit);
      eh   = '0;
      el   = '0;
      case (o)
         MULT, MULTU: begin
            p  = (o == MULT) ? 64'(sa * sb) : 64'(ua * ub);
            eh = (p >> w) & mask;
            el = p & mask;
         end
         DIV: begin
            eh = 64'(sa % sb) & mask;
            el = 64'(sa / sb) & mask;
         end
         default: begin
            eh = 64'(ua % ub) & mask;
            el = 64'(ua / ub) & mask;
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         4:       return 32'h0000_0080;
         default: return $urandom;
      endcase
   endfunction

   task automatic wr(input logic [31:0] v_hi, input logic [31:0] v_lo, input bit do_hi, input bit do_lo);
      int s;
      logic [31:0] mask;
      s    = sel8 ? 1 : 0;
      mask = sel8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
      @(negedge clk);
      wdata = v_hi;
      if (sel8) hi_we8 = do_hi; else hi_we32 = do_hi;
      @(posedge clk); #1;
      hi_we8 = 1'b0; hi_we32 = 1'b0;
      if (do_hi) exp_hi[s] = v_hi & mask;
      @(negedge clk);
      wdata = v_lo;
      if (sel8) lo_we8 = do_lo; else lo_we32 = do_lo;
      @(posedge clk); #1;
      lo_we8 = 1'b0; lo_we32 = 1'b0;
      if (do_lo) exp_lo[s] = v_lo & mask;
      chk("wr_hi", {32'd0, hi_o}, {32'd0, exp_hi[s]});
      chk("wr_lo", {32'd0, lo_o}, {32'd0, exp_lo[s]});
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb, input bit pulse_chk);
      int s, w, k, busy_err;
      logic [31:0] mask;
      logic [63:0] eh, el;
      bit dz, exp_busy;
      s    = sel8 ? 1 : 0;
      w    = sel8 ? 8 : 32;
      mask = sel8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
      dz   = o[1] && ((bb & mask) == 32'd0);
      if (dz) begin
         eh = {32'd0, exp_hi[s]};
         el = {32'd0, exp_lo[s]};
      end else begin
         model(o, aa, bb, w, eh, el);
      end
      @(negedge clk);
      op = o; a = aa; b = bb;
      if (sel8) start8 = 1'b1; else start32 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; start32 = 1'b0;
      k = 0;
      busy_err = 0;
      forever begin
         exp_busy = !dz && (k <= w);
         if (busy_o !== exp_busy) busy_err++;
         if (done_o === 1'b1 || k > 3 * w + 10) break;
         @(posedge clk); #1;
         k++;
      end
      chk("latency", 64'(k), dz ? 64'd0 : 64'(w + 1));
      chk("busy_window", 64'(busy_err), 64'd0);
      chk("hi", {32'd0, hi_o}, eh);
      chk("lo", {32'd0, lo_o}, el);
      chk("div_zero", {63'd0, dz_o}, {63'd0, dz});
      exp_hi[s] = eh[31:0];
      exp_lo[s] = el[31:0];
      if (pulse_chk) begin
         @(posedge clk); #1;
         chk("done_pulse", {63'd0, done_o}, 64'd0);
         chk("dz_sticky", {63'd0, dz_o}, {63'd0, dz});
      end
   endtask

   initial begin
      int seen;
      reset = 1'b1;
      start32 = 1'b0; start8 = 1'b0;
      hi_we32 = 1'b0; lo_we32 = 1'b0; hi_we8 = 1'b0; lo_we8 = 1'b0;
      op = MULT; a = '0; b = '0; wdata = '0;
      sel8 = 1'b0;
      exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state32", {29'd0, busy32, done32, dz32, hi32}, 64'd0);
      chk("rst_lo32", {32'd0, lo32}, 64'd0);
      chk("rst_state8", {45'd0, busy8, done8, dz8, hi8, lo8}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed vectors.
      run_op(MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
      chk("mult_hi_const", {32'd0, hi32}, 64'hFFFF_FFFF);
      chk("mult_lo_const", {32'd0, lo32}, 64'hFFFF_FFFA);
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu_hi_const", {32'd0, hi32}, 64'hFFFF_FFFE);
      chk("multu_lo_const", {32'd0, lo32}, 64'h0000_0001);
      run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
      chk("div_lo_const", {32'd0, lo32}, 64'hFFFF_FFFD);
      chk("div_hi_const", {32'd0, hi32}, 64'hFFFF_FFFF);
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      chk("divovf_lo_const", {32'd0, lo32}, 64'h8000_0000);
      chk("divovf_hi_const", {32'd0, hi32}, 64'd0);

      // Divide by zero keeps HI/LO, then the next start clears the flag.
      wr(32'h11, 32'h22, 1'b1, 1'b1);
      run_op(DIVU, 32'd7, 32'd0, 1'b1);
      chk("dz_hi_const", {32'd0, hi32}, 64'h11);
      chk("dz_lo_const", {32'd0, lo32}, 64'h22);
      run_op(MULTU, 32'd2, 32'd3, 1'b1);
      chk("dz_clear_lo", {32'd0, lo32}, 64'd6);

      // Start and writes while busy are ignored.
      @(negedge clk);
      op = MULTU; a = 32'd5; b = 32'd5; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      op = MULT; a = 32'd9; b = 32'd7; start32 = 1'b1;
      hi_we32 = 1'b1; lo_we32 = 1'b1; wdata = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      start32 = 1'b0; hi_we32 = 1'b0; lo_we32 = 1'b0;
      seen = 0;
      for (int c = 0; c < 60 && seen == 0; c++) begin
         @(posedge clk); #1;
         if (done32) seen = 1;
      end
      chk("blk_done_seen", 64'(seen), 64'd1);
      chk("blk_lo", {32'd0, lo32}, 64'd25);
      chk("blk_hi", {32'd0, hi32}, 64'd0);
      exp_hi[0] = 32'd0;
      exp_lo[0] = 32'd25;

      // Randomised mix, including back-to-back starts in the done cycle.
      for (int i = 0; i < 40; i++) begin
         logic [1:0] o;
         o = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            wr($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         run_op(o, pick(), ($urandom_range(0, 9) == 0) ? 32'd0 : pick(), 1'($urandom_range(0, 1)));
      end

      // Reset mid-operation aborts with no done.
      wr(32'hAA, 32'hBB, 1'b1, 1'b1);
      @(negedge clk);
      op = MULTU; a = 32'd5; b = 32'd5; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_hi", {32'd0, hi32}, 64'd0);
      chk("abort_lo", {32'd0, lo32}, 64'd0);
      chk("abort_flags", {61'd0, busy32, done32, dz32}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (done32 || busy32) seen++;
      end
      chk("abort_no_done", 64'(seen), 64'd0);
      exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;

      // Narrow instance.
      sel8 = 1'b1;
      run_op(MULT, 32'h80, 32'h80, 1'b1);
      chk("w8_hi_const", {32'd0, hi_o}, 64'h40);
      chk("w8_lo_const", {32'd0, lo_o}, 64'h00);
      run_op(DIV, 32'h80, 32'hFF, 1'b1);
      for (int i = 0; i < 15; i++) begin
         logic [1:0] o;
         o = 2'($urandom_range(0, 3));
         run_op(o, pick(), ($urandom_range(0, 7) == 0) ? 32'd0 : pick(), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
